// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the instruction control sequencer.
//   state_e      : sequencer states (fetch T0..T2, execute T3..T5, IDLE, HALT)
//   OP_*         : 5-bit instruction opcodes (ir[31:27])
//   IR_*         : instruction register field bit positions
//   ALU_ADD      : ALU operation used during fetch to increment the PC
//   is_alu_op()  : true for register-format ALU opcodes
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T0   = 3'd1,
      T1   = 3'd2,
      T2   = 3'd3,
      T3   = 3'd4,
      T4   = 3'd5,
      T5   = 3'd6,
      HALT = 3'd7
   } state_e;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_ADD = OP_ADD;

   localparam int IR_OP_MSB = 31;
   localparam int IR_OP_LSB = 27;
   localparam int IR_RA_MSB = 26;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_MSB = 22;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_MSB = 18;
   localparam int IR_RC_LSB = 15;

   function automatic logic is_alu_op(input logic [4:0] op);
      return (op == OP_ADD)  || (op == OP_SUB)  || (op == OP_AND) ||
             (op == OP_OR)   || (op == OP_SHR)  || (op == OP_SHRA) ||
             (op == OP_SHL)  || (op == OP_ROR)  || (op == OP_ROL);
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: binary register index to one-hot select.
//   idx_i    : register index
//   en_i     : when low the output is all zeros
//   onehot_o : one-hot select, at most one bit set
module reg_select_decoder #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic [IDX_W-1:0]    idx_i,
   input  logic                en_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute control for register-format ALU
// instructions plus nop and halt. All outputs are Moore strobes decoded
// from the state register (mdr_enable additionally follows mem_ready in T1).
//   clk, clr (async active-low), run (sampled in T0), ir, mem_ready
//   datapath strobes: pc_out, mar_enable, inc_pc, z_enable, zlow_out,
//                     pc_enable, read, mdr_enable, mdr_out, ir_enable, y_enable
//   r_out / r_enable : one-hot register bus select / load
//   alu_op           : ALU operation
//   running          : high unless reset or halted
//   illegal          : single-cycle pulse in T3 on an undefined opcode
//
// state | meaning
// IDLE  | just out of reset, moves to T0
// T0    | wait for run; PC -> MAR, Z <= PC + 1
// T1    | Z -> PC, memory read; waits here until mem_ready
// T2    | MDR -> IR
// T3    | decode: Rb -> Y, or nop / halt / illegal
// T4    | Rc through ALU -> Z
// T5    | Z -> Ra
// HALT  | stopped until clr
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OP_W     = 5
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   input  logic [DATA_W-1:0]   ir,
   input  logic                mem_ready,
   output logic                pc_out,
   output logic                mar_enable,
   output logic                inc_pc,
   output logic                z_enable,
   output logic                zlow_out,
   output logic                pc_enable,
   output logic                read,
   output logic                mdr_enable,
   output logic                mdr_out,
   output logic                ir_enable,
   output logic                y_enable,
   output logic [NUM_REGS-1:0] r_out,
   output logic [NUM_REGS-1:0] r_enable,
   output logic [OP_W-1:0]     alu_op,
   output logic                running,
   output logic                illegal
);

   state_e state_q, state_d;

   logic [OP_W-1:0] op;
   logic [3:0]      ra, rb, rc;
   logic [3:0]      rout_idx;
   logic            rout_en;
   logic            renable_en;
   logic            unused_ir_bits;

   assign op = ir[IR_OP_MSB:IR_OP_LSB];
   assign ra = ir[IR_RA_MSB:IR_RA_LSB];
   assign rb = ir[IR_RB_MSB:IR_RB_LSB];
   assign rc = ir[IR_RC_MSB:IR_RC_LSB];
   assign unused_ir_bits = ^ir[IR_RC_LSB-1:0];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_out     = 1'b0;
      mar_enable = 1'b0;
      inc_pc     = 1'b0;
      z_enable   = 1'b0;
      zlow_out   = 1'b0;
      pc_enable  = 1'b0;
      read       = 1'b0;
      mdr_enable = 1'b0;
      mdr_out    = 1'b0;
      ir_enable  = 1'b0;
      y_enable   = 1'b0;
      alu_op     = '0;
      illegal    = 1'b0;
      rout_idx   = rb;
      rout_en    = 1'b0;
      renable_en = 1'b0;

      unique case (state_q)
         IDLE: state_d = T0;
         T0: begin
            if (run) begin
               pc_out     = 1'b1;
               mar_enable = 1'b1;
               inc_pc     = 1'b1;
               z_enable   = 1'b1;
               alu_op     = ALU_ADD;
               state_d    = T1;
            end
         end
         T1: begin
            // PC reloads from an unchanged Z every wait cycle, which is harmless.
            zlow_out   = 1'b1;
            pc_enable  = 1'b1;
            read       = 1'b1;
            mdr_enable = mem_ready;
            if (mem_ready) begin
               state_d = T2;
            end
         end
         T2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
            state_d   = T3;
         end
         T3: begin
            if (is_alu_op(op)) begin
               rout_en  = 1'b1;
               rout_idx = rb;
               y_enable = 1'b1;
               state_d  = T4;
            end else if (op == OP_NOP) begin
               state_d = T0;
            end else if (op == OP_HALT) begin
               state_d = HALT;
            end else begin
               illegal = 1'b1;
               state_d = T0;
            end
         end
         T4: begin
            rout_en  = 1'b1;
            rout_idx = rc;
            z_enable = 1'b1;
            alu_op   = op;
            state_d  = T5;
         end
         T5: begin
            zlow_out   = 1'b1;
            renable_en = 1'b1;
            state_d    = T0;
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Gating with clr lets running drop in the same cycle reset asserts.
   assign running = clr && (state_q != HALT);

   reg_select_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(4)) u_rout_dec (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (r_out)
   );

   reg_select_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(4)) u_renable_dec (
      .idx_i    (ra),
      .en_i     (renable_en),
      .onehot_o (r_enable)
   );

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Drives every datapath control strobe for register-format ALU instructions (add, sub, and, or, shr, shra, shl, ror, rol), plus nop and halt.
- Sequences instruction fetch (T0–T2) and execute (T3–T5) so the datapath no longer has to be hand-driven by a bench FSM.
- Decodes IR fields into one-hot register out/enable strobes and a 5-bit ALU opcode.
- Sits beside datapath; its outputs connect 1:1 to the datapath's control inputs.

Parameters:
- DATA_W, 32, IR and data width
- NUM_REGS, 16, general registers R0..R15
- OP_W, 5, opcode/alu_op width

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- run  in  1  high = allowed to fetch; sampled only in T0
- ir  in  DATA_W  instruction register contents from datapath
- mem_ready  in  1  memory read data valid on Mdatain
- pc_out  out  1  PC drives bus
- mar_enable  out  1  load MAR
- inc_pc  out  1  ALU increments PC value
- z_enable  out  1  load Z
- zlow_out  out  1  Z low drives bus
- pc_enable  out  1  load PC
- read  out  1  memory read request
- mdr_enable  out  1  load MDR
- mdr_out  out  1  MDR drives bus
- ir_enable  out  1  load IR
- y_enable  out  1  load Y
- r_out  out  NUM_REGS  one-hot register-to-bus select
- r_enable  out  NUM_REGS  one-hot register load
- alu_op  out  OP_W  ALU operation select
- running  out  1  high unless halted/reset
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Outputs are Moore, decoded combinationally from the state register; exactly one state per cycle except the T1 wait.
- IR fields: op = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- Opcodes:
  - add 00011, sub 00100, and 00101, or 00110, shr 00111
  - shra 01000, shl 01001, ror 01010, rol 01011
  - nop 11010, halt 11011
  - all others illegal
- Reset (clr=0, async): state=IDLE; all strobes, r_out, r_enable and alu_op are 0; running=0; illegal=0.
- IDLE: running=1 once clr is released; go to T0.
- T0: if run=0, stay in T0 with all strobes 0. Otherwise assert pc_out, mar_enable, inc_pc, z_enable, alu_op=00011 (add, used for the increment); next state T1.
- T1: assert zlow_out, pc_enable, read; mdr_enable = mem_ready.
  - Stay in T1 while mem_ready=0. Re-loading PC from unchanged Z each cycle is idempotent.
  - Advance to T2 on the cycle mem_ready=1.
- T2: assert mdr_out, ir_enable; next state T3.
- T3, decoded from ir:
  - ALU op: r_out[Rb], y_enable; next T4.
  - nop: no strobes; next T0.
  - halt: next HALT.
  - illegal: illegal=1 for this cycle; next T0.
- T4: r_out[Rc], z_enable, alu_op=op; next T5.
- T5: zlow_out, r_enable[Ra]; next T0.
- HALT: running=0, all strobes 0, held until clr. run has no effect.
- Invariants:
  - At most one bit of r_out and at most one bit of r_enable is set.
  - Never more than one bus driver (pc_out, zlow_out, mdr_out, r_out) in any cycle.
- Boundaries:
  - Ra=Rb=Rc is legal; R0 is writable.
  - clr asserted in any state, including a T1 wait, returns to IDLE immediately and zeroes outputs in the same cycle.
  - A mem_ready pulse outside T1 is ignored.
  - run deasserted mid-instruction does not stop the instruction; it is only checked in T0.
- Cycle count with no memory wait: 6 cycles per ALU instruction, 4 per nop/illegal.

Decomposition:
- Package cpu_pkg:
  - state enum: IDLE, T0, T1, T2, T3, T4, T5, HALT
  - opcode localparams
  - IR field bit positions
  - ALU_ADD used by T0
- Sub-module reg_select_decoder: 4-bit index plus enable → NUM_REGS one-hot. Instantiated twice (r_out, r_enable); r_out's index is muxed between Rb (T3) and Rc (T4).

Test Plan:
- Reset mid-T1: clr=0 during a mem_ready=0 wait → next sample shows all outputs 0, running=0; after release, IDLE→T0.
- shra fetch/execute: run=1, mem_ready tied 1, ir=32'h40090000 from T2 onward.
  - T0: pc_out, mar_enable, inc_pc, z_enable.
  - T1: zlow_out, pc_enable, read, mdr_enable.
  - T2: mdr_out, ir_enable.
  - T3: r_out=16'h0002, y_enable.
  - T4: r_out=16'h0004, alu_op=5'b01000, z_enable.
  - T5: r_enable=16'h0001, zlow_out.
  - Back to T0 after 6 cycles.
- Memory wait: mem_ready=0 for 3 cycles in T1 → read held high for 4 cycles; mdr_enable high only on the 4th cycle; T2 follows.
- Opcode coverage: each ALU opcode with ir = {op, 4'd5, 4'd6, 4'd7, 15'd0} → alu_op=op in T4; r_enable=16'h0020 in T5.
- nop (op 11010) → T3 emits no strobes, then T0; illegal op 11111 → illegal pulses one cycle in T3, then T0.
- halt (op 11011) → HALT with running=0 and no strobes for ≥20 cycles regardless of run; clr pulse restarts at IDLE.
